// File: rtl/reaction_btn_cond.sv
// reaction_btn_cond
// -----------------------------------------------------------------------------
// Input conditioning for the reaction-timer game. Each raw button or switch is
// synchronised into clk, debounced against a shared millisecond tick, and
// turned into a clean level plus one-cycle press and release pulses. The
// downstream game FSM therefore sees exactly one event per physical press.
//
// Parameters
//   N_CH     : number of independent channels (ch0 = start, ch1 = stop)
//   TICK_DIV : clk cycles per debounce tick (>= 2)
//   DB_MS    : ticks a new input value must persist before it is accepted (>= 1)
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   btn_raw     : asynchronous raw button levels
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on a debounced 0->1 transition
//   btn_release : one-cycle pulse on a debounced 1->0 transition
//   tick_ms     : one-cycle strobe every TICK_DIV cycles
// -----------------------------------------------------------------------------
module reaction_btn_cond #(
  parameter int N_CH     = 2,
  parameter int TICK_DIV = 100_000,
  parameter int DB_MS    = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            tick_ms
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(DB_MS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_MS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  logic [N_CH-1:0]  meta_q;
  logic [N_CH-1:0]  sync_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;

  // Two-flop synchroniser; only sync_q is used past this point.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= {N_CH{1'b0}};
      sync_q <= {N_CH{1'b0}};
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  // Free-running divider; the strobe is registered so it appears the cycle
  // after the counter sits at its last value.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = {DIV_W{1'b0}};
      tick_d = 1'b1;
    end else begin
      div_d  = div_q + DIV_W'(1);
      tick_d = 1'b0;
    end
  end

  // Divider and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= {DIV_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_ms = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Debounce next-state logic. A revert of sync in a WAIT state takes
    // priority over a coincident tick, so a late glitch never commits.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ZERO: begin
          if (sync_q[i]) begin
            state_d = WAIT1;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ZERO;
          end
        end
        WAIT1: begin
          if (!sync_q[i]) begin
            state_d = ZERO;
          end else if (tick_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ONE;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = WAIT1;
          end
        end
        ONE: begin
          if (!sync_q[i]) begin
            state_d = WAIT0;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ONE;
          end
        end
        WAIT0: begin
          if (sync_q[i]) begin
            state_d = ONE;
          end else if (tick_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = ZERO;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = WAIT0;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
      // Level is registered from the next state so the pulse and the new
      // level appear in the same cycle.
      level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    // Per-channel state, count and output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= ZERO;
        cnt_q     <= {CNT_W{1'b0}};
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_reaction_btn_cond.sv
// Testbench for reaction_btn_cond: table-driven phases, hand-written latency and
// reset sequences, then randomized stimulus, all checked cycle by cycle against
// an event-level reference model of the debounce rules.
module tb_reaction_btn_cond;

  localparam int NCH = 2;
  localparam int TD  = 10;
  localparam int DB  = 3;
  localparam int TD4 = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] btn_raw;
  logic [NCH-1:0] lvl, prs, rel;
  logic           tick;
  logic [NCH-1:0] lvl4, prs4, rel4;
  logic           tick4;

  always #5 clk = ~clk;

  reaction_btn_cond #(.N_CH(NCH), .TICK_DIV(TD), .DB_MS(DB)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .tick_ms(tick)
  );

  reaction_btn_cond #(.N_CH(NCH), .TICK_DIV(TD4), .DB_MS(DB)) dut4 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl4), .btn_press(prs4), .btn_release(rel4), .tick_ms(tick4)
  );

  // Reference model: raw history, cycles since reset, and per channel an
  // accepted level plus a pending-change tick tally.
  logic [NCH-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel, m_pend;
  logic           m_tick, m_tick4;
  int             m_ticks [NCH];
  int             m_since;

  int vectors;
  int miscompares;

  task automatic model_step(input logic [NCH-1:0] raw, input logic r);
    logic seen;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_pend = '0;
      m_tick = 1'b0; m_tick4 = 1'b0; m_since = 0;
      for (int c = 0; c < NCH; c++) m_ticks[c] = 0;
    end else begin
      seen = m_tick;
      for (int c = 0; c < NCH; c++) begin
        m_prs[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (m_pend[c]) begin
          if (m_s2[c] == m_lvl[c]) begin
            m_pend[c] = 1'b0;
          end else if (seen) begin
            m_ticks[c]++;
            if (m_ticks[c] == DB) begin
              m_lvl[c]  = ~m_lvl[c];
              m_pend[c] = 1'b0;
              if (m_lvl[c]) m_prs[c] = 1'b1;
              else          m_rel[c] = 1'b1;
            end
          end
        end else if (m_s2[c] != m_lvl[c]) begin
          m_pend[c]  = 1'b1;
          m_ticks[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_since++;
      m_tick  = (m_since % TD) == 0;
      m_tick4 = (m_since % TD4) == 0;
    end
  endtask

  task automatic check_outputs();
    vectors++;
    if ({lvl, prs, rel, tick, tick4} !== {m_lvl, m_prs, m_rel, m_tick, m_tick4}) begin
      miscompares++;
      $display("FAIL cycle t=%0t: lvl/prs/rel/tick/tick4 got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
               $time, lvl, prs, rel, tick, tick4, m_lvl, m_prs, m_rel, m_tick, m_tick4);
    end
  endtask

  // One clock: drive at the negedge, advance the model, compare at the next negedge.
  task automatic step(input logic [NCH-1:0] raw, input logic r);
    btn_raw = raw;
    rst     = r;
    model_step(raw, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic           rst;
    logic [NCH-1:0] raw;
    int             cycles;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] npress;
    logic [NCH-1:0] nrel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [NCH-1:0] raw, int cyc,
                              logic [NCH-1:0] l, logic [NCH-1:0] np, logic [NCH-1:0] nr);
    vec_t v;
    v.rst = r; v.raw = raw; v.cycles = cyc; v.lvl = l; v.npress = np; v.nrel = nr;
    return v;
  endfunction

  initial begin
    int pc [NCH];
    int rc [NCH];
    int n;
    int hold [NCH];
    logic [NCH-1:0] rr;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    btn_raw     = '0;

    tbl.push_back(mk(1'b1, 2'b00,  2, 2'b00, 2'b00, 2'b00)); // reset state
    tbl.push_back(mk(1'b0, 2'b01, 60, 2'b01, 2'b01, 2'b00)); // clean press ch0
    tbl.push_back(mk(1'b0, 2'b00, 60, 2'b00, 2'b00, 2'b01)); // release ch0
    tbl.push_back(mk(1'b0, 2'b01, 15, 2'b00, 2'b00, 2'b00)); // 15-cycle glitch
    tbl.push_back(mk(1'b0, 2'b00, 40, 2'b00, 2'b00, 2'b00));
    for (int k = 0; k < 15; k++) begin                       // ch1 bounce, 4-cycle toggles
      tbl.push_back(mk(1'b0, (k % 2 == 0) ? 2'b10 : 2'b00, 4, 2'b00, 2'b00, 2'b00));
    end
    tbl.push_back(mk(1'b0, 2'b10, 60, 2'b10, 2'b10, 2'b00)); // settled: one press
    tbl.push_back(mk(1'b0, 2'b11, 60, 2'b11, 2'b01, 2'b00)); // ch0 joins
    tbl.push_back(mk(1'b0, 2'b00, 60, 2'b00, 2'b00, 2'b11)); // simultaneous release

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < NCH; c++) begin pc[c] = 0; rc[c] = 0; end
      for (int k = 0; k < tbl[i].cycles; k++) begin
        step(tbl[i].raw, tbl[i].rst);
        for (int c = 0; c < NCH; c++) begin
          if (prs[c] === 1'b1) pc[c]++;
          if (rel[c] === 1'b1) rc[c]++;
        end
      end
      vectors++;
      if (lvl !== tbl[i].lvl || pc[0] != int'(tbl[i].npress[0]) || pc[1] != int'(tbl[i].npress[1]) ||
          rc[0] != int'(tbl[i].nrel[0]) || rc[1] != int'(tbl[i].nrel[1])) begin
        miscompares++;
        $display("FAIL table[%0d]: lvl=%b press=%0d,%0d rel=%0d,%0d want lvl=%b press=%b rel=%b",
                 i, lvl, pc[1], pc[0], rc[1], rc[0], tbl[i].lvl, tbl[i].npress, tbl[i].nrel);
      end
    end

    // Release of both channels must land in one cycle with level 00 after.
    // (checked cycle-exactly by the model above); now press latency on ch0.
    n = 0;
    do begin
      step(2'b01, 1'b0);
      n++;
    end while (prs[0] !== 1'b1 && n < 60);
    vectors++;
    if (prs[0] !== 1'b1 || n < 23 || n > 34) begin
      miscompares++;
      $display("FAIL press_latency: got %0d cycles (seen=%b) want 23..34", n, prs[0]);
    end
    step(2'b01, 1'b0);
    expect_val("press_width", int'(prs[0]), 0);
    expect_val("level_after_press", int'(lvl[0]), 1);
    expect_val("ch1_quiet", int'({lvl[1], prs[1], rel[1]}), 0);
    for (int k = 0; k < 60; k++) step(2'b00, 1'b0);

    // Reset while WAIT1 holds a partial count of 2 ticks.
    step(2'b00, 1'b1);
    for (int k = 0; k < 22; k++) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    expect_val("outputs_after_reset", int'({lvl, prs, rel, tick}), 0);
    n = 0;
    do begin
      step(2'b01, 1'b0);
      n++;
    end while (prs[0] !== 1'b1 && n < 60);
    expect_val("press_after_reset", n, 31);
    for (int k = 0; k < 60; k++) step(2'b00, 1'b0);

    // Randomized hold lengths with occasional resets.
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    rr = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          rr[c]   = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 45);
        end
        hold[c]--;
      end
      step(rr, ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
